// File: rtl/aes_trojan_trigger_seq.sv
// aes_trojan_trigger_seq: watches the plaintext stream for SEQ0..SEQ3 in order and raises a sticky Tj_Trig.
// Define TRIG_GAP_TIMEOUT_EN to drop partial progress after GAP_MAX idle cycles in S1..S3.
module aes_trojan_trigger_seq #(
`ifdef TRIG_GAP_TIMEOUT_EN
    parameter int unsigned    GAP_MAX = 16,
`endif
    parameter logic [127:0] SEQ0 = 128'h3243f6a8885a308d313198a2e0370734,
    parameter logic [127:0] SEQ1 = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] SEQ2 = 128'h00000000000000000000000000000000,
    parameter logic [127:0] SEQ3 = 128'hffffffffffffffffffffffffffffffff
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_valid,
    input  logic [127:0] data,
    output logic         Tj_Trig,
    output logic [2:0]   stage
);
    typedef enum logic [2:0] {IDLE = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, ARMED = 3'd4} state_t;
    state_t       state_q, state_d;
    logic         trig_q;
    logic [127:0] exp_w;
    always_comb exp_w = state_q == S1 ? SEQ1 : state_q == S2 ? SEQ2 : state_q == S3 ? SEQ3 : SEQ0;
`ifdef TRIG_GAP_TIMEOUT_EN
    logic [15:0] gap_q, gap_d;
    logic        busy, timeout;
    always_comb begin
        busy    = state_q == S1 || state_q == S2 || state_q == S3;
        timeout = busy && !data_valid && ({1'b0, gap_q} + 17'd1 >= 17'(GAP_MAX));
        gap_d   = (data_valid || !busy || timeout) ? 16'd0 : gap_q + 16'd1;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) gap_q <= '0;
        else gap_q <= gap_d;
`endif
    // In IDLE exp_w is SEQ0, so a match there advances to S1 like any other stage.
    always_comb begin
        state_d = state_q;
        if (data_valid && state_q != ARMED)
            state_d = data == exp_w ? state_t'(state_q + 3'd1) : (data == SEQ0 ? S1 : IDLE);
`ifdef TRIG_GAP_TIMEOUT_EN
        else if (timeout)
            state_d = IDLE;
`endif
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= state_d == ARMED;
        end
    assign Tj_Trig = trig_q;
    assign stage   = state_q;
endmodule

// File: tb/tb_aes_trojan_trigger_seq.sv
// tb_aes_trojan_trigger_seq: directed scoreboard bench for the trigger sequence detector.
module tb_aes_trojan_trigger_seq;
    localparam logic [127:0] SEQ0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] SEQ1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ2 = 128'h00000000000000000000000000000000;
    localparam logic [127:0] SEQ3 = 128'hffffffffffffffffffffffffffffffff;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         data_valid = 1'b0;
    logic [127:0] data = '0;
    logic         Tj_Trig;
    logic [2:0]   stage;
    int           vectors = 0;
    int           miscompares = 0;
    logic [3:0]   sb_q[$];

    aes_trojan_trigger_seq dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .Tj_Trig(Tj_Trig), .stage(stage)
    );

    always #5 clk = ~clk;

    // exp packs {Tj_Trig, stage}
    task automatic check(string tag, logic [3:0] exp);
        vectors++;
        assert ({Tj_Trig, stage} === exp) else begin
            miscompares++;
            $error("FAIL %s: observed trig=%b stage=%0d, expected trig=%b stage=%0d",
                   tag, Tj_Trig, stage, exp[3], exp[2:0]);
        end
    endtask

    task automatic step(string tag, logic v, logic [127:0] d, logic [2:0] exp_stage);
        data_valid = v;
        data = v ? d : 'x;
        sb_q.push_back({exp_stage == 3'd4, exp_stage});
        @(posedge clk);
        #1;
        check(tag, sb_q.pop_front());
    endtask

    task automatic idle(string tag, int n, logic [2:0] exp_stage);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, exp_stage);
    endtask

    task automatic reset_mid(string tag);
        data_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check(tag, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check(tag, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            data_valid = 1'($urandom);
            data = $urandom_range(0, 1) ? SEQ0 : {$urandom, $urandom, $urandom, $urandom};
            check("reset_hold", 4'd0);
        end
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("reset_release", 4'd0);

        step("happy_s0", 1'b1, SEQ0, 3'd1);
        step("happy_s1", 1'b1, SEQ1, 3'd2);
        step("happy_s2", 1'b1, SEQ2, 3'd3);
        step("happy_s3", 1'b1, SEQ3, 3'd4);
        for (int i = 0; i < 1000; i++)
            step("armed_hold", 1'($urandom), $urandom_range(0, 3) == 0 ? SEQ0 : {$urandom, $urandom, $urandom, $urandom}, 3'd4);
        reset_mid("reset_armed");

        step("ovl_a", 1'b1, SEQ0, 3'd1);
        step("ovl_b", 1'b1, SEQ1, 3'd2);
        step("ovl_restart", 1'b1, SEQ0, 3'd1);
        step("ovl_c", 1'b1, SEQ1, 3'd2);
        step("ovl_d", 1'b1, SEQ2, 3'd3);
        step("ovl_e", 1'b1, SEQ3, 3'd4);
        reset_mid("reset_ovl");

        step("mis_a", 1'b1, SEQ0, 3'd1);
        step("mis_b", 1'b1, SEQ1, 3'd2);
        step("mis_drop", 1'b1, 128'h1, 3'd0);
        step("s3_a", 1'b1, SEQ0, 3'd1);
        step("s3_b", 1'b1, SEQ1, 3'd2);
        step("s3_c", 1'b1, SEQ2, 3'd3);
        step("s3_restart", 1'b1, SEQ0, 3'd1);
        step("s3_skip", 1'b1, SEQ2, 3'd0);
        idle("idle_in_idle", 5, 3'd0);
        step("solo_seq3", 1'b1, SEQ3, 3'd0);

`ifdef TRIG_GAP_TIMEOUT_EN
        step("to_a", 1'b1, SEQ0, 3'd1);
        idle("to_wait", 15, 3'd1);
        step("to_fire", 1'b0, '0, 3'd0);
        step("gap_a", 1'b1, SEQ0, 3'd1);
        idle("gap_wait", 15, 3'd1);
        step("gap_edge", 1'b1, SEQ1, 3'd2);
        step("gap_c", 1'b1, SEQ2, 3'd3);
        step("gap_d", 1'b1, SEQ3, 3'd4);
        idle("gap_armed", 20, 3'd4);
`else
        step("gap_a", 1'b1, SEQ0, 3'd1);
        idle("gap_hold", 100, 3'd1);
        step("gap_b", 1'b1, SEQ1, 3'd2);
        step("gap_c", 1'b1, SEQ2, 3'd3);
        step("gap_d", 1'b1, SEQ3, 3'd4);
`endif
        reset_mid("reset_gap");

        step("rs_a", 1'b1, SEQ0, 3'd1);
        step("rs_b", 1'b1, SEQ1, 3'd2);
        step("rs_c", 1'b1, SEQ2, 3'd3);
        reset_mid("reset_s3");
        step("rs_seq3_alone", 1'b1, SEQ3, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
